// File: rtl/decimal_rx_pkg.sv
// decimal_rx_pkg: shared states, ASCII constants, error codes and byte classifiers for the decimal receive parser
package decimal_rx_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SIGN, S_DIGITS, S_HOLD, S_DRAIN} state_t;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] SP    = 8'h20;
  localparam logic [7:0] COMMA = 8'h2C;
  localparam logic [7:0] MINUS = 8'h2D;
  localparam logic [7:0] ZERO  = 8'h30;
  localparam logic [7:0] NINE  = 8'h39;
  localparam logic [1:0] ERR_OVERRUN  = 2'd0;
  localparam logic [1:0] ERR_BADCHAR  = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;
  function automatic logic is_digit(input logic [7:0] b);
    return b >= ZERO && b <= NINE;
  endfunction
  function automatic logic is_term(input logic [7:0] b);
    return b == CR || b == LF || b == SP || b == COMMA;
  endfunction
endpackage

// File: rtl/dec_accum_step.sv
// dec_accum_step: combinational acc*10+d with exact signed-range overflow detection
//   acc      unsigned magnitude so far
//   d        next decimal digit 0..9
//   neg      number is negative (allows one extra unit of magnitude)
//   sum      low WIDTH bits of acc*10+d
//   overflow magnitude exceeds 2^(WIDTH-1)-1 (positive) or 2^(WIDTH-1) (negative)
module dec_accum_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [3:0]       d,
  input  logic             neg,
  output logic [WIDTH-1:0] sum,
  output logic             overflow
);
  logic [WIDTH+3:0] wide;
  logic [WIDTH+3:0] limit;
  // acc never exceeds 2^(WIDTH-1), so 4 extra bits hold acc*10+9 without wrapping
  assign wide = ({4'b0, acc} << 3) + ({4'b0, acc} << 1) + {{WIDTH{1'b0}}, d};
  assign limit = ((WIDTH+4)'(1) << (WIDTH-1)) - (WIDTH+4)'(!neg);
  assign overflow = wide > limit;
  assign sum = wide[WIDTH-1:0];
endmodule

// File: rtl/decimal_rx_parser.sv
// decimal_rx_parser: assembles ASCII signed decimal numbers from a UART byte stream
//   clk, rst            clock, synchronous active-high reset
//   rx_data, new_rx_data received byte and its one-cycle strobe
//   value, value_valid  parsed two's-complement number, held until value_ready
//   value_ready         consumer accept
//   err, err_code       one-cycle error pulse: 0 overrun, 1 bad char, 2 overflow, 3 timeout
module decimal_rx_parser
  import decimal_rx_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             new_rx_data,
  output logic [WIDTH-1:0] value,
  output logic             value_valid,
  input  logic             value_ready,
  output logic             err,
  output logic [1:0]       err_code
);
  state_t           state, state_n;
  logic [WIDTH-1:0] acc, acc_n, step, value_n;
  logic             neg, neg_n, ovf, err_n, dig, term, tmo;
  logic [1:0]       code_n;
  logic [31:0]      cnt, cnt_n;
  logic [3:0]       d;
  assign d    = rx_data[3:0];
  assign dig  = is_digit(rx_data);
  assign term = is_term(rx_data);
  // fires on the idle cycle that would bring the counter up to TIMEOUT_CYCLES
  assign tmo  = (TIMEOUT_CYCLES > 0) && (cnt + 32'd1 == 32'(TIMEOUT_CYCLES));
  dec_accum_step #(.WIDTH(WIDTH)) u_step (
    .acc(acc),
    .d(d),
    .neg(neg),
    .sum(step),
    .overflow(ovf)
  );
  always_comb begin
    state_n = state;
    acc_n   = acc;
    neg_n   = neg;
    cnt_n   = cnt;
    value_n = value;
    err_n   = 1'b0;
    code_n  = err_code;
    case (state)
      S_IDLE: if (new_rx_data) begin
        cnt_n = '0;
        if (dig) begin
          acc_n   = WIDTH'(d);
          neg_n   = 1'b0;
          state_n = S_DIGITS;
        end else if (rx_data == MINUS) begin
          acc_n   = '0;
          neg_n   = 1'b1;
          state_n = S_SIGN;
        end else if (!term) begin
          err_n   = 1'b1;
          code_n  = ERR_BADCHAR;
          state_n = S_DRAIN;
        end
      end
      S_SIGN: if (new_rx_data) begin
        cnt_n   = '0;
        acc_n   = WIDTH'(d);
        err_n   = !dig;
        code_n  = dig ? code_n : ERR_BADCHAR;
        state_n = dig ? S_DIGITS : term ? S_IDLE : S_DRAIN;
      end else begin
        cnt_n   = tmo ? '0 : cnt + 32'd1;
        err_n   = tmo;
        code_n  = tmo ? ERR_TIMEOUT : code_n;
        state_n = tmo ? S_IDLE : state;
      end
      S_DIGITS: if (new_rx_data) begin
        cnt_n = '0;
        if (dig) begin
          acc_n   = step;
          err_n   = ovf;
          code_n  = ovf ? ERR_OVERFLOW : code_n;
          state_n = ovf ? S_DRAIN : state;
        end else if (term) begin
          value_n = neg ? -acc : acc;
          state_n = S_HOLD;
        end else begin
          err_n   = 1'b1;
          code_n  = ERR_BADCHAR;
          state_n = S_DRAIN;
        end
      end else begin
        cnt_n   = tmo ? '0 : cnt + 32'd1;
        err_n   = tmo;
        code_n  = tmo ? ERR_TIMEOUT : code_n;
        state_n = tmo ? S_IDLE : state;
      end
      S_HOLD: begin
        err_n   = new_rx_data;
        code_n  = new_rx_data ? ERR_OVERRUN : code_n;
        state_n = value_ready ? S_IDLE : state;
      end
      S_DRAIN: state_n = (new_rx_data && term) ? S_IDLE : state;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state       <= S_IDLE;
      acc         <= '0;
      neg         <= 1'b0;
      cnt         <= '0;
      value       <= '0;
      value_valid <= 1'b0;
      err         <= 1'b0;
      err_code    <= '0;
    end else begin
      state       <= state_n;
      acc         <= acc_n;
      neg         <= neg_n;
      cnt         <= cnt_n;
      value       <= value_n;
      value_valid <= state_n == S_HOLD;
      err         <= err_n;
      err_code    <= code_n;
    end
endmodule

// File: tb/tb_decimal_rx_parser.sv
// tb_decimal_rx_parser: directed self-checking bench for decimal_rx_parser
module tb_decimal_rx_parser;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        new_rx_data;
  logic [31:0] value;
  logic        value_valid;
  logic        value_ready;
  logic        err;
  logic [1:0]  err_code;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  decimal_rx_parser #(.WIDTH(32), .TIMEOUT_CYCLES(20)) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .new_rx_data(new_rx_data),
    .value(value),
    .value_valid(value_valid),
    .value_ready(value_ready),
    .err(err),
    .err_code(err_code)
  );
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input logic [7:0] b);
    rx_data = b;
    new_rx_data = 1'b1;
    @(posedge clk);
    #1;
    new_rx_data = 1'b0;
  endtask
  task automatic test_reset;
    total++; if (value !== 32'd0) begin bad++; $display("FAIL reset_value got=%0h exp=0", value); end
    total++; if (value_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", value_valid); end
    total++; if (err !== 1'b0 || err_code !== 2'd0) begin bad++; $display("FAIL reset_err got=%0b/%0d exp=0/0", err, err_code); end
  endtask
  task automatic test_basic;
    string s = "1234";
    for (int i = 0; i < s.len(); i++) begin
      send(s[i]);
      total++; if (err !== 1'b0 || value_valid !== 1'b0) begin bad++; $display("FAIL basic_digit%0d got=err%0b vv%0b exp=0/0", i, err, value_valid); end
    end
    send(8'h0D);
    total++; if (value_valid !== 1'b1 || value !== 32'd1234) begin bad++; $display("FAIL basic_value got=vv%0b %0d exp=1 1234", value_valid, value); end
    tick(1);
    total++; if (value_valid !== 1'b0) begin bad++; $display("FAIL basic_one_cycle got=%0b exp=0", value_valid); end
    send(8'h0A);
    total++; if (err !== 1'b0 || value_valid !== 1'b0) begin bad++; $display("FAIL basic_lf got=err%0b vv%0b exp=0/0", err, value_valid); end
  endtask
  task automatic test_extremes;
    string a = "-2147483648 ";
    string b = "214748364";
    for (int i = 0; i < a.len(); i++) send(a[i]);
    total++; if (value_valid !== 1'b1 || value !== 32'h8000_0000) begin bad++; $display("FAIL min_value got=vv%0b %0h exp=1 80000000", value_valid, value); end
    tick(1);
    for (int i = 0; i < b.len(); i++) send(b[i]);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL pre_overflow got=%0b exp=0", err); end
    send("8");
    total++; if (err !== 1'b1 || err_code !== 2'd2) begin bad++; $display("FAIL overflow got=%0b/%0d exp=1/2", err, err_code); end
    send(" ");
    total++; if (err !== 1'b0 || value_valid !== 1'b0) begin bad++; $display("FAIL overflow_drain got=err%0b vv%0b exp=0/0", err, value_valid); end
    send("7");
    send(8'h0A);
    total++; if (value_valid !== 1'b1 || value !== 32'd7) begin bad++; $display("FAIL after_overflow got=vv%0b %0d exp=1 7", value_valid, value); end
    tick(1);
  endtask
  task automatic test_badchar;
    send("1");
    send("2");
    send("a");
    total++; if (err !== 1'b1 || err_code !== 2'd1) begin bad++; $display("FAIL badchar got=%0b/%0d exp=1/1", err, err_code); end
    send("4");
    total++; if (err !== 1'b0) begin bad++; $display("FAIL drain_digit got=%0b exp=0", err); end
    send(",");
    total++; if (err !== 1'b0 || value_valid !== 1'b0) begin bad++; $display("FAIL drain_term got=err%0b vv%0b exp=0/0", err, value_valid); end
    send("5");
    send(",");
    total++; if (value_valid !== 1'b1 || value !== 32'd5) begin bad++; $display("FAIL after_bad got=vv%0b %0d exp=1 5", value_valid, value); end
    tick(1);
  endtask
  task automatic test_zeros;
    string a = "-00 ";
    string b = "007 ";
    for (int i = 0; i < a.len(); i++) send(a[i]);
    total++; if (value_valid !== 1'b1 || value !== 32'd0) begin bad++; $display("FAIL neg_zero got=vv%0b %0h exp=1 0", value_valid, value); end
    tick(1);
    for (int i = 0; i < b.len(); i++) send(b[i]);
    total++; if (value_valid !== 1'b1 || value !== 32'd7) begin bad++; $display("FAIL lead_zero got=vv%0b %0d exp=1 7", value_valid, value); end
    tick(1);
  endtask
  task automatic test_hold;
    value_ready = 1'b0;
    send("9");
    send(8'h0A);
    total++; if (value_valid !== 1'b1 || value !== 32'd9) begin bad++; $display("FAIL hold_value got=vv%0b %0d exp=1 9", value_valid, value); end
    send("3");
    total++; if (err !== 1'b1 || err_code !== 2'd0 || value !== 32'd9 || value_valid !== 1'b1) begin bad++; $display("FAIL overrun1 got=err%0b/%0d vv%0b %0d exp=1/0 1 9", err, err_code, value_valid, value); end
    send(8'h0A);
    total++; if (err !== 1'b1 || err_code !== 2'd0 || value !== 32'd9 || value_valid !== 1'b1) begin bad++; $display("FAIL overrun2 got=err%0b/%0d vv%0b %0d exp=1/0 1 9", err, err_code, value_valid, value); end
    tick(1);
    total++; if (err !== 1'b0 || value_valid !== 1'b1) begin bad++; $display("FAIL hold_steady got=err%0b vv%0b exp=0/1", err, value_valid); end
    value_ready = 1'b1;
    tick(1);
    total++; if (value_valid !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL hold_release got=vv%0b err%0b exp=0/0", value_valid, err); end
    tick(2);
    total++; if (value_valid !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL hold_idle got=vv%0b err%0b exp=0/0", value_valid, err); end
  endtask
  task automatic test_timeout;
    send("-");
    send("4");
    tick(19);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL timeout_early got=%0b exp=0", err); end
    tick(1);
    total++; if (err !== 1'b1 || err_code !== 2'd3) begin bad++; $display("FAIL timeout got=%0b/%0d exp=1/3", err, err_code); end
    tick(1);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL timeout_pulse got=%0b exp=0", err); end
    send("5");
    send(" ");
    total++; if (value_valid !== 1'b1 || value !== 32'd5) begin bad++; $display("FAIL timeout_idle got=vv%0b %0d exp=1 5", value_valid, value); end
    tick(1);
    send("-");
    send(8'h0D);
    total++; if (err !== 1'b1 || err_code !== 2'd1) begin bad++; $display("FAIL sign_term got=%0b/%0d exp=1/1", err, err_code); end
    send("8");
    send(" ");
    total++; if (value_valid !== 1'b1 || value !== 32'd8) begin bad++; $display("FAIL sign_idle got=vv%0b %0d exp=1 8", value_valid, value); end
    tick(1);
  endtask
  task automatic test_reset_mid;
    send("5");
    send("6");
    rst = 1'b1;
    tick(1);
    total++; if (value !== 32'd0 || value_valid !== 1'b0 || err !== 1'b0 || err_code !== 2'd0) begin bad++; $display("FAIL mid_reset got=%0h vv%0b err%0b/%0d exp=0", value, value_valid, err, err_code); end
    rst = 1'b0;
    tick(1);
    total++; if (value !== 32'd0 || value_valid !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL post_reset got=%0h vv%0b err%0b exp=0", value, value_valid, err); end
    send("7");
    total++; if (err !== 1'b0) begin bad++; $display("FAIL post_reset_digit got=%0b exp=0", err); end
    send(8'h0D);
    total++; if (value_valid !== 1'b1 || value !== 32'd7 || err !== 1'b0) begin bad++; $display("FAIL post_reset_value got=vv%0b %0d err%0b exp=1 7 0", value_valid, value, err); end
    tick(1);
  endtask
  initial begin
    rst = 1'b1;
    rx_data = 8'h00;
    new_rx_data = 1'b0;
    value_ready = 1'b1;
    tick(2);
    test_reset;
    rst = 1'b0;
    tick(1);
    test_basic;
    test_extremes;
    test_badchar;
    test_zeros;
    test_hold;
    test_timeout;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/decimal_rx_parser.md
# decimal_rx_parser

Receive-side counterpart of the decimal number printer: consumes ASCII bytes from the UART receiver and assembles signed decimal numbers into a WIDTH-bit two's-complement value. It sits between the UART rx (rx_data/new_rx_data strobe) and the solver/control logic that loads operands such as obs and xi entries. Each completed number is offered on a valid/ready handshake. Malformed input, overflow and stalls are reported as error pulses.

## Interface
- WIDTH, 32, result width (two's complement), 8..32
- TIMEOUT_CYCLES, 0, max idle cycles between bytes of one number; 0 disables the timeout
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rx_data  in  8  received byte, valid when new_rx_data=1
- new_rx_data  in  1  one-cycle strobe per received byte
- value  out  WIDTH  parsed signed number, stable while value_valid=1
- value_valid  out  1  number available; held until accepted
- value_ready  in  1  consumer accepts when value_valid & value_ready
- err  out  1  one-cycle error pulse
- err_code  out  2  0 overrun, 1 bad character, 2 overflow, 3 timeout; meaningful only when err=1

## Operation
- Character classes:
  - digit '0'..'9';
  - minus '-' (0x2D);
  - terminator CR 0x0D, LF 0x0A, space 0x20, comma 0x2C;
  - everything else is bad.
- States: IDLE, SIGN, DIGITS, HOLD, DRAIN.
- IDLE:
  - digit: acc=d, neg=0, go DIGITS;
  - '-': neg=1, acc=0, go SIGN;
  - terminator: ignored, so CRLF and repeated spaces are harmless;
  - bad: err code 1, go DRAIN.
- SIGN:
  - digit: acc=d, go DIGITS;
  - any other byte: err code 1. Go DRAIN, or go IDLE if that byte was a terminator.
- DIGITS:
  - digit: acc = acc*10 + d.
  - Overflow when the magnitude exceeds 2^(WIDTH-1)-1 (neg=0) or 2^(WIDTH-1) (neg=1). On overflow: err code 2, go DRAIN.
  - Terminator: value = neg ? -acc : acc, go HOLD.
  - Bad: err code 1, go DRAIN.
- HOLD:
  - value_valid=1 until the handshake, then go IDLE.
  - Any byte arriving in HOLD, including in the handshake cycle, is dropped with err code 0.
- DRAIN: discard bytes until a terminator, then go IDLE. No further err pulses are raised while in DRAIN.
- Accumulator arithmetic:
  - Magnitude is held unsigned in WIDTH bits.
  - The next value is computed in WIDTH+4 bits, so the overflow test is exact.
  - Leading zeros are allowed, in any number.
  - "-0" yields 0.
- Timeout (TIMEOUT_CYCLES>0):
  - The idle counter clears on every byte accepted in SIGN or DIGITS.
  - When the counter reaches TIMEOUT_CYCLES in SIGN or DIGITS: err code 3, go IDLE. The partial number is discarded.
  - The timeout is not active in IDLE, HOLD or DRAIN.

## Timing
- Reset values:
  - state IDLE;
  - value 0, value_valid 0, err 0, err_code 0;
  - acc 0, neg 0, idle counter 0.
- All outputs are registered.
- value_valid rises the cycle after the terminator strobe; latency is 1 cycle. value is valid in the same cycle.
- err/err_code assert the cycle after the offending strobe, or after the timeout count is reached, for exactly 1 cycle.
- Handshake: transfer occurs on a cycle with value_valid & value_ready. value_valid is 0 on the next cycle, and the parser is in IDLE that same cycle. A byte strobed in that IDLE cycle is processed normally.
- At most one byte is consumed per cycle. new_rx_data strobes may arrive back-to-back with no gaps.
- rst mid-number or in HOLD discards all state immediately; the pending value is lost.
- A timeout and a byte in the same cycle: the byte wins, and the counter clears.

## Structure
- Package decimal_rx_pkg contains:
  - state enum;
  - ASCII constants (CR, LF, SP, COMMA, MINUS, ZERO, NINE);
  - err_code constants ERR_OVERRUN, ERR_BADCHAR, ERR_OVERFLOW, ERR_TIMEOUT.
- Sub-module dec_accum_step: combinational acc*10+d with WIDTH parameter, neg input and overflow output.
- The FSM, timeout counter and output registers stay in the top module.

## Test plan
- "1234\r", value_ready=1 → value=1234, value_valid high 1 cycle starting 1 cycle after the '\r' strobe; the following '\n' is ignored with no err.
- "-2147483648 " → value=0x80000000. Then "2147483648 " → err code 2 on the final '8'; the space returns to IDLE; then "7\n" → 7.
- "12a4,5," → err code 1 on 'a'; '4' and ',' are silently drained; then value=5.
- value_ready=0, send "9\n3\n" → value=9 is held with no changes. Two err pulses with code 0 occur (on '3' and '\n'). Raising ready → transfer, then IDLE with no further output.
- TIMEOUT_CYCLES=20: "-4", then 20 idle cycles → err code 3, state IDLE. Then "-\r" → err code 1, then IDLE.
- "56", assert rst 1 cycle, then "7\r" → value=7 with no err pulse; all outputs are 0 during and just after reset.
